// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator arbiter: datapath width, FSM encodings
// and comparator mode constants.
package cmp_pkg;

  localparam int CMP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    RESP = 2'b10
  } cmpState_t;

  localparam logic CMP_SLT = 1'b0;
  localparam logic CMP_EQ  = 1'b1;

endpackage

// File: rtl/comparator.sv
// Shared 16-bit comparator: signed less-than or equality, 1-bit result
// zero-extended to WIDTH.
module comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ControlSignal,
  output logic [WIDTH-1:0] R
);

  logic isLess;
  logic isEqual;

  assign isLess  = $signed(A) < $signed(B);
  assign isEqual = (A == B);
  assign R       = {{(WIDTH-1){1'b0}}, (ControlSignal == CMP_EQ) ? isEqual : isLess};

endmodule

// File: rtl/rr_arb2.sv
// Stateless two-way round-robin grant; the caller owns lastGrant.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       lastGrant,
  output logic       grantValid,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~lastGrant;  // contention: the port not served last time wins
      default: grant = 1'b0;
    endcase
  end

  assign grantValid = |valid;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between branch-resolve (port 0)
// and the slt/compare path (port 1); one operation in flight at a time.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output cmpState_t        dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Requesters hold valid and operands stable until ready; ready is
  // only ever raised in IDLE. A response is held until its owner's ready.

  cmpState_t        state;
  cmpState_t        nextState;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             opMode;
  logic [WIDTH-1:0] resReg;
  logic [WIDTH-1:0] cmpR;
  logic             owner;
  logic             lastGrant;
  logic             grantValid;
  logic             grant;
  logic             accept;

  rr_arb2 uArb (
    .valid      ({req1_valid, req0_valid}),
    .lastGrant  (lastGrant),
    .grantValid (grantValid),
    .grant      (grant)
  );

  comparator #(.WIDTH(WIDTH)) uCmp (
    .A             (opA),
    .B             (opB),
    .ControlSignal (opMode),
    .R             (cmpR)
  );

  always_comb begin
    nextState  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_data   = '0;
    case (state)
      IDLE: begin
        req0_ready = grantValid & ~grant;
        req1_ready = grantValid & grant;
        if (grantValid) begin
          accept    = 1'b1;
          nextState = EVAL;
        end
      end
      EVAL: nextState = RESP;
      RESP: begin
        rsp_data   = resReg;
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        // only the owner's ready can retire the response
        if (owner ? rsp1_ready : rsp0_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      opA       <= '0;
      opB       <= '0;
      opMode    <= 1'b0;
      resReg    <= '0;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      state <= nextState;
      if (accept) begin
        opA       <= grant ? req1_a : req0_a;
        opB       <= grant ? req1_b : req0_b;
        opMode    <= grant ? req1_mode : req0_mode;
        owner     <= grant;
        lastGrant <= grant;
      end
      if (state == EVAL) resReg <= cmpR;
    end
  end

  assign dbgState = state;

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one 16-bit comparator between two requesters: branch-resolve logic (port 0) and the slt/ALU-compare path (port 1).
- Accepts compare requests over valid/ready handshakes and arbitrates round-robin.
- Drives the comparator from registered operands, then returns the registered 1-bit-extended result to the winning requester over a valid/ready response channel.
- Sits in the execute stage between the control unit and the comparator instance.

Parameters:
WIDTH, 16, operand and result width; must match the comparator.
Comparator contract, fixed:
- ControlSignal=0: R = (A < B, signed) ? 1 : 0.
- ControlSignal=1: R = (A == B) ? 1 : 0.
- R is zero-extended to WIDTH.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
req0_valid  input  1  port 0 request present.
req0_ready  output  1  port 0 request accepted this cycle.
req0_a  input  WIDTH  port 0 operand A.
req0_b  input  WIDTH  port 0 operand B.
req0_mode  input  1  port 0 ControlSignal.
req1_valid / req1_ready / req1_a / req1_b / req1_mode  same as port 0, for port 1.
rsp0_valid  output  1  result for port 0 available.
rsp0_ready  input  1  port 0 consumes the result.
rsp1_valid  output  1  result for port 1 available.
rsp1_ready  input  1  port 1 consumes the result.
rsp_data  output  WIDTH  result, shared by both response channels; meaningful only while a rsp*_valid is high.

Behaviour:
- Only one operation may be outstanding. FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Arbitrate over {req0_valid, req1_valid}.
  - If exactly one is valid, grant that port.
  - If both are valid, grant the port != last_grant.
  - Assert ready of the granted port only, combinationally, in the same cycle.
  - On handshake: latch a, b, mode into op regs; latch owner = granted port; last_grant <= owner; go to EVAL.
  - No valid request: stay in IDLE; both ready = 0.
- EVAL:
  - op regs drive the comparator A/B/ControlSignal.
  - Capture R into res_reg; go to RESP.
- RESP:
  - rsp_data = res_reg.
  - Assert rsp<owner>_valid; the other rsp*_valid stays 0.
  - Hold until rsp<owner>_ready=1, then go to IDLE next cycle.
  - rsp_ready from the non-owner is ignored.
- Latency:
  - Handshake at edge T: EVAL during T+1, rsp_valid high from T+2.
  - With rsp_ready tied high, the next accept is possible at T+3.
  - Sustained throughput: 1 op / 3 cycles.
- req*_ready is 0 in EVAL and RESP. Requesters must hold valid and operands stable until ready.
- Operands and mode are sampled only at the handshake; later input changes do not affect the in-flight operation.
- Reset values, applied on any cycle including mid-operation:
  - state=IDLE; op regs=0; res_reg=0; owner=0.
  - last_grant=1, so port 0 wins the first contention.
  - All ready and valid outputs = 0; rsp_data = 0.
  - An in-flight result is discarded, with no response.
- Starvation-free: under continuous contention, grants strictly alternate 0,1,0,1.
- A single persistent requester is granted every 3 cycles.

Decomposition:
- Shared package (cmp_pkg):
  - WIDTH default.
  - FSM state encodings: IDLE=2'b00, EVAL=2'b01, RESP=2'b10.
  - Mode constants CMP_SLT=1'b0, CMP_EQ=1'b1.
- Natural sub-module: rr_arb2.
  - Combinational two-way round-robin grant from the valid bits and last_grant.
  - Has no state; last_grant lives in cmp_arbiter.
- The comparator is instantiated unchanged inside cmp_arbiter.

Test Plan:
1. Reset held 3 cycles, then released with no requests -> all ready/valid 0, rsp_data=0, state IDLE.
2. Port 0 only: a=100, b=50, mode=0; rsp0_ready=1 -> req0_ready same cycle; rsp0_valid two cycles later with rsp_data=0; rsp1_valid stays 0.
3. Both ports valid in the same cycle:
   - Port 0: a=2, b=10000, mode=0.
   - Port 1: a=7, b=7, mode=1.
   - Required response: port 0 granted first, rsp_data=1 on rsp0; port 1 granted at +3, rsp_data=1 on rsp1.
   - Holding both valid for 6 ops gives grant order 0,1,0,1,0,1.
4. Backpressure: port 1, a=0xFFFF (-1), b=0, mode=0, with rsp1_ready=0 for 5 cycles -> rsp1_valid stays high with rsp_data=1; req0_valid=1 meanwhile sees req0_ready=0; rsp1_ready=1 -> IDLE, port 0 then granted.
5. Operand change after accept: port 0 a=1, b=0, mode=1 accepted, then inputs changed to a=0, b=0 during EVAL -> rsp_data=0 (the latched values are used).
6. Reset asserted in EVAL and again in RESP -> next cycle all outputs 0, no response emitted; a fresh request afterwards (a=0, b=1, mode=0) returns rsp_data=1.
